// File: rtl/fp_normalize_pipe.sv
// fp_normalize_pipe: two-stage pipelined mantissa normalizer.
// Stage 1 computes the leading-zero count and the shift headroom above the
// per-format minimum normal exponent. Stage 2 clamps the shift to that
// headroom, barrel-shifts the mantissa and adjusts the exponent.
// Optional build macro FNORM_FLUSH_DEN_EN: flush denormal results to a
// signed zero (res_den stays 1 so the caller still sees the underflow).
module fp_normalize_pipe #(
  parameter int unsigned      MANT_W   = 64,
  parameter int unsigned      EXP_W    = 16,
  parameter logic [EXP_W-1:0] EMIN_EXT = EXP_W'(16'h0001),
  parameter logic [EXP_W-1:0] EMIN_DBL = EXP_W'(16'h3C01)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clkEn,
  input  logic              en,
  input  logic              isDBL,
  input  logic              sgn,
  input  logic [EXP_W-1:0]  expA,
  input  logic [MANT_W-1:0] mant,
  output logic              res_valid,
  output logic              res_sgn,
  output logic [EXP_W-1:0]  res_exp,
  output logic [MANT_W-1:0] res_mant,
  output logic              res_den,
  output logic              res_zero
);

  // SH_W bits drive the barrel levels; one extra bit lets lzc reach MANT_W.
  localparam int unsigned SH_W  = $clog2(MANT_W);
  localparam int unsigned LZC_W = SH_W + 1;
  localparam int unsigned CMP_W = (EXP_W > LZC_W) ? EXP_W : LZC_W;

  // Leading-zero count; scanning upward leaves the highest set bit's count.
  function automatic logic [LZC_W-1:0] count_lz(input logic [MANT_W-1:0] m);
    count_lz = LZC_W'(MANT_W);
    for (int i = 0; i < MANT_W; i++) begin
      if (m[i]) count_lz = LZC_W'(MANT_W - 1 - i);
    end
  endfunction

  // ---------------- Stage 1 ----------------
  logic [EXP_W-1:0]  emin_c;
  logic [EXP_W-1:0]  hr_d;
  logic [LZC_W-1:0]  lzc_d;
  logic              zero1_d;

  logic              v1_q;
  logic              sgn1_q;
  logic [EXP_W-1:0]  exp1_q;
  logic [MANT_W-1:0] mant1_q;
  logic [LZC_W-1:0]  lzc1_q;
  logic [EXP_W-1:0]  hr1_q;
  logic              zero1_q;

  // Stage 1 combinational: format minimum, headroom, lzc and zero detect.
  always_comb begin
    // NOTE: every always_comb output gets a value on every path (here
    // unconditionally) so no latch is inferred.
    emin_c  = isDBL ? EMIN_DBL : EMIN_EXT;
    hr_d    = (expA > emin_c) ? (expA - emin_c) : '0;
    lzc_d   = count_lz(mant);
    zero1_d = (mant == '0);
  end

  // Stage 1 register: valid follows en on enabled edges, data only on en.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    // NOTE: data registers are reset too, because the outputs must read 0
    // after reset rather than leftover pipeline contents.
    if (rst) begin
      v1_q    <= 1'b0;
      sgn1_q  <= 1'b0;
      exp1_q  <= '0;
      mant1_q <= '0;
      lzc1_q  <= '0;
      hr1_q   <= '0;
      zero1_q <= 1'b0;
    end else if (clkEn) begin
      v1_q <= en;
      if (en) begin
        sgn1_q  <= sgn;
        exp1_q  <= expA;
        mant1_q <= mant;
        lzc1_q  <= lzc_d;
        hr1_q   <= hr_d;
        zero1_q <= zero1_d;
      end
    end
  end

  // ---------------- Stage 2 ----------------
  logic              lzc_gt_hr;
  logic [LZC_W-1:0]  shift;
  logic [MANT_W-1:0] shifted;
  logic [EXP_W-1:0]  exp2_d;
  logic [MANT_W-1:0] mant2_d;
  logic              den2_d;
  logic              zero2_d;

  logic              valid_q;
  logic              sgn2_q;
  logic [EXP_W-1:0]  exp2_q;
  logic [MANT_W-1:0] mant2_q;
  logic              den2_q;
  logic              zero2_q;

  // Stage 2 combinational: clamp the shift, barrel-shift, adjust exponent.
  always_comb begin
    lzc_gt_hr = CMP_W'(lzc1_q) > CMP_W'(hr1_q);
    // When clamped, headroom < lzc <= MANT_W, so it fits in LZC_W bits.
    shift     = lzc_gt_hr ? LZC_W'(hr1_q) : lzc1_q;

    shifted = mant1_q;
    for (int i = 0; i < SH_W; i++) begin
      if (shift[i]) shifted = shifted << (1 << i);
    end
    // A full-width shift only happens for a zero mantissa.
    if (shift[SH_W]) shifted = '0;

    mant2_d = shifted;
    exp2_d  = zero1_q ? '0 : (exp1_q - EXP_W'(shift));
    den2_d  = ~zero1_q & lzc_gt_hr;
    zero2_d = zero1_q;
`ifdef FNORM_FLUSH_DEN_EN
    if (den2_d) begin
      mant2_d = '0;
      exp2_d  = '0;
      zero2_d = 1'b1;
    end
`endif
  end

  // Stage 2 register: result data updates only for valid results, so the
  // outputs hold their last value while res_valid is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      sgn2_q  <= 1'b0;
      exp2_q  <= '0;
      mant2_q <= '0;
      den2_q  <= 1'b0;
      zero2_q <= 1'b0;
    end else if (clkEn) begin
      valid_q <= v1_q;
      if (v1_q) begin
        sgn2_q  <= sgn1_q;
        exp2_q  <= exp2_d;
        mant2_q <= mant2_d;
        den2_q  <= den2_d;
        zero2_q <= zero2_d;
      end
    end
  end

  assign res_valid = valid_q;
  assign res_sgn   = sgn2_q;
  assign res_exp   = exp2_q;
  assign res_mant  = mant2_q;
  assign res_den   = den2_q;
  assign res_zero  = zero2_q;

endmodule

// File: tb/tb_fp_normalize_pipe.sv
// tb_fp_normalize_pipe: directed table vectors plus hand-written sequences
// for stall, hold, streaming and mid-flight reset of fp_normalize_pipe.
// Honours FNORM_FLUSH_DEN_EN when the bundle is built with it.
module tb_fp_normalize_pipe;

  localparam int MANT_W = 64;
  localparam int EXP_W  = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              clkEn;
  logic              en;
  logic              isDBL;
  logic              sgn;
  logic [EXP_W-1:0]  expA;
  logic [MANT_W-1:0] mant;
  logic              res_valid;
  logic              res_sgn;
  logic [EXP_W-1:0]  res_exp;
  logic [MANT_W-1:0] res_mant;
  logic              res_den;
  logic              res_zero;

  int n_tests = 0;
  int n_fail  = 0;

  fp_normalize_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .clkEn     (clkEn),
    .en        (en),
    .isDBL     (isDBL),
    .sgn       (sgn),
    .expA      (expA),
    .mant      (mant),
    .res_valid (res_valid),
    .res_sgn   (res_sgn),
    .res_exp   (res_exp),
    .res_mant  (res_mant),
    .res_den   (res_den),
    .res_zero  (res_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic              sgn;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
    logic              den;
    logic              zero;
  } res_t;

  typedef struct {
    logic              isdbl;
    logic              sgn;
    logic [EXP_W-1:0]  expa;
    logic [MANT_W-1:0] mant;
    res_t              exp_res;
  } vec_t;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic res_t apply_flush(input res_t r);
    res_t o = r;
`ifdef FNORM_FLUSH_DEN_EN
    if (o.den) begin
      o.mant = '0;
      o.exp  = '0;
      o.zero = 1'b1;
    end
`endif
    return o;
  endfunction

  // Reference: shift one bit at a time until normal or at the format minimum.
  function automatic res_t model(input logic isdbl, input logic s,
                                 input logic [EXP_W-1:0] e_in,
                                 input logic [MANT_W-1:0] m_in);
    res_t r;
    logic [EXP_W-1:0]  emin = isdbl ? 16'h3C01 : 16'h0001;
    logic [EXP_W-1:0]  e    = e_in;
    logic [MANT_W-1:0] m    = m_in;
    r.sgn = s;
    if (m == '0) begin
      r.exp = '0; r.mant = '0; r.den = 1'b0; r.zero = 1'b1;
    end else begin
      for (int k = 0; k < MANT_W; k++) begin
        if (!m[MANT_W-1] && e > emin) begin
          m = m << 1;
          e = e - 1'b1;
        end
      end
      r.exp = e; r.mant = m; r.den = !m[MANT_W-1]; r.zero = 1'b0;
    end
    return apply_flush(r);
  endfunction

  task automatic check_res(input string tag, input res_t r);
    check({tag, ".sgn"},  128'(res_sgn),  128'(r.sgn));
    check({tag, ".exp"},  128'(res_exp),  128'(r.exp));
    check({tag, ".mant"}, 128'(res_mant), 128'(r.mant));
    check({tag, ".den"},  128'(res_den),  128'(r.den));
    check({tag, ".zero"}, 128'(res_zero), 128'(r.zero));
  endtask

  task automatic drive(input logic v, input logic d, input logic s,
                       input logic [EXP_W-1:0] e, input logic [MANT_W-1:0] m);
    en = v; isDBL = d; sgn = s; expA = e; mant = m;
  endtask

  vec_t vecs[10];
  res_t zero_res;
  res_t q[$];

  initial begin
    // Hand-computed vectors: {isDBL, sgn, expA, mant, {sgn, exp, mant, den, zero}}
    vecs[0] = '{1'b0, 1'b0, 16'h4000, 64'h0000_0001_0000_0000, '{1'b0, 16'h3FE1, 64'h8000_0000_0000_0000, 1'b0, 1'b0}};
    vecs[1] = '{1'b0, 1'b1, 16'h0005, 64'h10,                  '{1'b1, 16'h0001, 64'h100,                 1'b1, 1'b0}};
    vecs[2] = '{1'b1, 1'b0, 16'h3C04, 64'h1000_0000_0000_0000, '{1'b0, 16'h3C01, 64'h8000_0000_0000_0000, 1'b0, 1'b0}};
    vecs[3] = '{1'b0, 1'b0, 16'h1234, 64'h8000_0000_0000_0001, '{1'b0, 16'h1234, 64'h8000_0000_0000_0001, 1'b0, 1'b0}};
    vecs[4] = '{1'b0, 1'b1, 16'h4000, 64'h0,                   '{1'b1, 16'h0000, 64'h0,                   1'b0, 1'b1}};
    vecs[5] = '{1'b1, 1'b0, 16'h3000, 64'hFF,                  '{1'b0, 16'h3000, 64'hFF,                  1'b1, 1'b0}};
    vecs[6] = '{1'b0, 1'b0, 16'h0001, 64'h4000_0000_0000_0000, '{1'b0, 16'h0001, 64'h4000_0000_0000_0000, 1'b1, 1'b0}};
    vecs[7] = '{1'b1, 1'b1, 16'h3C05, 64'h0100_0000_0000_0000, '{1'b1, 16'h3C01, 64'h1000_0000_0000_0000, 1'b1, 1'b0}};
    vecs[8] = '{1'b0, 1'b0, 16'h0000, 64'h1,                   '{1'b0, 16'h0000, 64'h1,                   1'b1, 1'b0}};
    vecs[9] = '{1'b0, 1'b0, 16'h7FFF, 64'h1,                   '{1'b0, 16'h7FC0, 64'h8000_0000_0000_0000, 1'b0, 1'b0}};
    zero_res = '{1'b0, 16'h0, 64'h0, 1'b0, 1'b0};

    // Reset state
    rst = 1'b1; clkEn = 1'b1;
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    tick(); tick();
    rst = 1'b0;
    check("reset.valid", 128'(res_valid), 128'(0));
    check_res("reset", zero_res);

    // Table: one vector at a time, checking the two-edge latency.
    foreach (vecs[i]) begin
      drive(1'b1, vecs[i].isdbl, vecs[i].sgn, vecs[i].expa, vecs[i].mant);
      tick();
      drive(1'b0, 1'b0, 1'b0, '0, '0);
      check($sformatf("vec%0d.valid_early", i), 128'(res_valid), 128'(0));
      tick();
      check($sformatf("vec%0d.valid", i), 128'(res_valid), 128'(1));
      check_res($sformatf("vec%0d", i), apply_flush(vecs[i].exp_res));
    end

    // Hold: with no new input, valid drops and the last result stays put.
    tick();
    check("hold.valid", 128'(res_valid), 128'(0));
    check_res("hold", apply_flush(vecs[9].exp_res));

    // Zero input followed by a 3-cycle stall; en is ignored during the stall.
    tick();
    drive(1'b1, 1'b0, 1'b1, 16'h4000, '0);
    tick();
    clkEn = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 16'h2222, 64'h0000_0ABC_0000_0000);
    for (int c = 0; c < 3; c++) begin
      tick();
      check($sformatf("stall%0d.valid", c), 128'(res_valid), 128'(0));
    end
    clkEn = 1'b1;
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    tick();
    check("stall.valid", 128'(res_valid), 128'(1));
    check_res("stall", '{1'b1, 16'h0, 64'h0, 1'b0, 1'b1});
    tick();
    check("stall.after_valid", 128'(res_valid), 128'(0));
    check("stall.after_zero", 128'(res_zero), 128'(1));

    // Back-to-back stream of 8 inputs against the bit-serial model.
    begin
      int got = 0;
      for (int c = 0; c < 12; c++) begin
        if (c < 8) begin
          logic              d = 1'(($urandom & 32'h1));
          logic              s = 1'(($urandom & 32'h1));
          logic [EXP_W-1:0]  e = (c % 2 == 0) ? 16'($urandom_range(0, 16'hFFFF))
                                               : (d ? 16'h3C01 : 16'h0001) + 16'($urandom_range(0, 70));
          logic [MANT_W-1:0] m = {$urandom, $urandom} >> $urandom_range(0, 63);
          drive(1'b1, d, s, e, m);
          q.push_back(model(d, s, e, m));
        end else begin
          drive(1'b0, 1'b0, 1'b0, '0, '0);
        end
        tick();
        if (res_valid) begin
          if (q.size() == 0) begin
            check("stream.unexpected", 128'(1), 128'(0));
          end else begin
            check_res($sformatf("stream%0d", got), q.pop_front());
            got++;
          end
        end
      end
      check("stream.count", 128'(got), 128'(8));
    end

    // Reset mid-flight with clkEn low: everything clears, nothing stale emerges.
    drive(1'b1, 1'b0, 1'b1, 16'h4000, 64'h0000_0001_0000_0000);
    tick();
    drive(1'b1, 1'b1, 1'b1, 16'h3C04, 64'h1000_0000_0000_0000);
    tick();
    rst = 1'b1; clkEn = 1'b0;
    tick();
    rst = 1'b0; clkEn = 1'b1;
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    check("midrst.valid", 128'(res_valid), 128'(0));
    check_res("midrst", zero_res);
    for (int c = 0; c < 3; c++) begin
      tick();
      check($sformatf("midrst.after%0d", c), 128'(res_valid), 128'(0));
    end
    check("midrst.after_mant", 128'(res_mant), 128'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_normalize_pipe.md
Name: fp_normalize_pipe

Overview:
- Two-stage pipelined floating-point mantissa normalizer for the FPU datapath.
- Left-shifts a mantissa to remove leading zeros and adjusts the exponent by the same amount.
- Clamps the shift so the exponent never drops below the per-format minimum normal exponent; results that remain sub-normal are flagged denormal.
- Generalised over mantissa/exponent width and per-format minimum exponent; replaces fixed double/extended-only normalization.

Parameters:
- MANT_W, 64, mantissa width including explicit integer bit at MSB; power of two, 8..128.
- EXP_W, 16, biased exponent width.
- EMIN_EXT, 16'h0001, minimum normal biased exponent in extended mode.
- EMIN_DBL, 16'h3C01, minimum normal biased exponent in double mode (double bias re-based onto the EXP_W field).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- clkEn  in  1  global pipeline enable; 0 freezes every register.
- en  in  1  input valid.
- isDBL  in  1  format select: 1 = double (EMIN_DBL), 0 = extended (EMIN_EXT).
- sgn  in  1  sign.
- expA  in  EXP_W  biased exponent.
- mant  in  MANT_W  mantissa.
- res_valid  out  1  result valid.
- res_sgn  out  1  sign, passed through.
- res_exp  out  EXP_W  adjusted exponent.
- res_mant  out  MANT_W  shifted mantissa.
- res_den  out  1  result is denormal.
- res_zero  out  1  mantissa was zero.

Behaviour:
- Reset (rst=1 at a clk edge): all pipeline valids and all outputs clear to 0. Reset overrides clkEn and discards in-flight data.
- Latency is 2 clkEn-qualified cycles.
  - Input is sampled on an edge with clkEn=1.
  - Result appears on the outputs after the second subsequent clkEn=1 edge.
  - Throughput is 1 per cycle; no back-pressure port.
- clkEn=0: every stage holds its value, including valids; en is ignored in that cycle.
- Stage 1 (registered):
  - emin = isDBL ? EMIN_DBL : EMIN_EXT.
  - headroom = expA > emin ? expA - emin : 0, computed as unsigned EXP_W.
  - lzc = leading-zero count of mant, range 0..MANT_W.
  - zero = (mant == 0).
  - Register sgn, expA, mant, lzc, headroom, zero, and valid = en.
- Stage 2 (registered):
  - shift = min(lzc, headroom).
  - res_mant = mant << shift, using a log2(MANT_W)-level barrel shifter.
  - res_exp = expA - shift.
  - res_den = ~zero & (lzc > headroom).
  - res_zero = zero.
- Zero input: res_exp = 0, res_mant = 0, res_den = 0, res_zero = 1.
- expA < emin (already sub-normal): headroom = 0, so there is no shift; mantissa and exponent pass through unchanged and res_den = 1 unless the mantissa is zero.
- lzc == headroom: result is exactly normal (MSB=1, exp=emin), res_den = 0.
- Outputs are don't-care-free: when res_valid=0 they hold the last values, except after reset, when they are 0.
- isDBL only selects emin; mantissa bit positions are identical for both formats. The upstream unit left-aligns double mantissas.

Optional Feature:
- Macro FNORM_FLUSH_DEN_EN.
- Defined: any result with res_den=1 is flushed. res_mant = 0, res_exp = 0, res_zero = 1, res_den = 1, and the sign is preserved.
- Not defined: denormal results are delivered unflushed, as described in Behaviour.

Test Plan:
- Normal shift: isDBL=0, expA=16'h4000, mant=64'h0000_0001_0000_0000, en=1 -> 2 cycles later res_valid=1, res_exp=16'h3FE1, res_mant=64'h8000_0000_0000_0000, res_den=0.
- Denormal clamp: isDBL=0, expA=16'h0005, mant=64'h10 -> res_exp=16'h0001, res_mant=64'h100, res_den=1. With FNORM_FLUSH_DEN_EN defined: res_mant=0, res_exp=0, res_zero=1.
- Double clamp boundary: isDBL=1, expA=16'h3C04, mant=64'h1000_0000_0000_0000 (lzc=3) -> res_exp=16'h3C01, res_mant=64'h8000_0000_0000_0000, res_den=0.
- Zero and stall: mant=0 at cycle 0 with clkEn held 0 for cycles 1-3 -> res_valid rises only after 2 clkEn=1 edges; res_zero=1, res_exp=0.
- Back-to-back stream: 8 consecutive en=1 inputs with random mant/expA -> outputs in order, one per cycle, all matching the reference model.
- Reset mid-flight: two valid inputs in the pipe, rst=1 for one edge (clkEn=0) -> res_valid=0 and all outputs 0 on the next cycle; no stale result emerges afterwards.
